divisor_queue: RTL
==================

# divisor_queue

- Parametrised successor of the single Divisor/Multiplicand load register: a DEPTH-entry first-word-fall-through operand queue feeding the sequential divider controller.
- Accepts divisor words on a W_ctrl strobe and optionally converts signed operands to sign + magnitude at push time.
- Presents the oldest entry on registered outputs that hold steady until the controller pops it.
- Lets the host queue several divisions ahead of the divider instead of reloading one register per operation.

## Interface
Parameters:
- WIDTH, 32: operand width in bits (≥2).
- DEPTH, 4: queue entries (power of two, ≥2).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- Reset  input  1  asynchronous, active-low reset; clears all state immediately on assertion.
- W_ctrl  input  1  push strobe; a push occurs on an edge where W_ctrl=1 and in_ready=1.
- Signed_mode  input  1  sampled with each push; 1 = treat Divisor_in as two's complement.
- Divisor_in  input  WIDTH  operand to push.
- Clear  input  1  synchronous flush; empties the queue.
- Pop  input  1  consumer takes the head; a pop occurs on an edge where Pop=1 and out_valid=1.
- in_ready  output  1  1 when count < DEPTH.
- out_valid  output  1  1 when count > 0.
- Divisor_out  output  WIDTH  magnitude of the head entry; 0 when empty.
- Divisor_sign  output  1  sign of the head entry; 0 when empty or unsigned.
- Divisor_zero  output  1  head magnitude is zero (see Configuration).
- count  output  $clog2(DEPTH)+1  occupancy, 0..DEPTH.

## Operation
- Storage: DEPTH entries of {sign, magnitude[WIDTH-1:0]}, written at wr_ptr and read at rd_ptr. Pointers wrap modulo DEPTH.
- Conversion at push:
  - Signed_mode=1 and Divisor_in[WIDTH-1]=1: sign=1, magnitude=(~Divisor_in+1) truncated to WIDTH. The most negative value 2^(WIDTH-1) is stored exactly as an unsigned magnitude.
  - Otherwise: sign=0, magnitude=Divisor_in.
- Output registers always equal the head entry after the edge's update, or 0 when the queue is empty. They do not change on edges with no push into an empty queue, no pop and no Clear.
- Push with no pop: count+1. Pop with no push: count−1. Simultaneous push and pop: count unchanged, both pointers advance.
- Full (count=DEPTH): W_ctrl is ignored unless Pop=1 on the same edge; a simultaneous pop frees the slot, so the push is accepted. in_ready depends only on count, not on Pop.
- Empty: Pop is ignored. A push and a pop on the same edge result in a push only.
- Clear has priority over push and pop on the same edge: count=0, pointers=0, outputs=0. Data presented with Clear is discarded.
- Reset (Reset=0), including mid-operation: count=0, pointers=0, Divisor_out=0, Divisor_sign=0, Divisor_zero=0, out_valid=0, in_ready=1. Stored array contents are don't-care.

## Timing
- Push into an empty queue at edge k: out_valid=1 and Divisor_out valid immediately after edge k (1-cycle latency).
- Pop at edge k: the next entry, or 0/out_valid=0, appears immediately after edge k.
- in_ready, out_valid and count are registered and change only on clock edges or Reset assertion.
- Reset release: the first edge with Reset=1 may push.

## Configuration
- DIVISOR_ZERO_FLAG_EN defined: Divisor_zero is a registered flag, 1 iff out_valid=1 and the head magnitude=0. It updates with the other outputs, so the controller can trap divide-by-zero before starting.
- Not defined: Divisor_zero is tied to 0 and no compare logic is built. The port remains present.

## Test plan
- Reset/hold: Reset=0, W_ctrl=1, Divisor_in=32'hFFFF_FFFF → outputs 0, in_ready=1, count=0; release Reset with W_ctrl=0 → outputs stay 0.
- Ordering: push 32'h0000_0007, 32'h0000_0003, 32'h0001_0000 (unsigned) → Divisor_out 7, then 3, then 65536 on successive pops; out_valid=0 after the third pop.
- Signed conversion:
  - Push 32'hFFFF_FFF9 with Signed_mode=1 → Divisor_out=7, Divisor_sign=1.
  - Push 32'h8000_0000 with Signed_mode=1 → Divisor_out=32'h8000_0000, Divisor_sign=1.
  - Push 32'hFFFF_FFF9 with Signed_mode=0 → Divisor_out=32'hFFFF_FFF9, Divisor_sign=0.
- Full/wrap (DEPTH=4):
  - Push 1..4 → in_ready=0; push 5 alone → ignored, count=4.
  - Push 6 with Pop on the same edge → count=4; subsequent pops yield 2,3,4,6.
- Clear/reset mid-operation:
  - Count=3, Clear with W_ctrl=1, Pop=1 → count=0, outputs 0.
  - Refill 2 entries, pulse Reset low between edges → outputs 0 asynchronously.
- Zero flag: push 0 then 5 → with DIVISOR_ZERO_FLAG_EN, Divisor_zero=1 then 0 after pop; without the macro, Divisor_zero=0 throughout.

Source files
------------

// File: rtl/divisor_queue.sv
// divisor_queue: FWFT operand queue of {sign, magnitude} entries feeding the divider controller.
// Latency: a push into an empty queue is visible on the outputs right after that edge; a pop exposes the next entry right after its edge.
// Backpressure: in_ready drops at count == DEPTH; a push at full is accepted only when a pop happens on the same edge.
//
// Optional feature: define DIVISOR_ZERO_FLAG_EN to build the registered Divisor_zero flag.
//
// Ports:
//   clk           rising-edge clock
//   Reset         asynchronous active-low reset
//   W_ctrl        push strobe (accepted when in_ready, or at full together with a pop)
//   Signed_mode   sampled with each push; 1 = Divisor_in is two's complement
//   Divisor_in    operand to push
//   Clear         synchronous flush, wins over push and pop
//   Pop           consumer takes the head (ignored when empty)
//   in_ready      count < DEPTH
//   out_valid     count > 0
//   Divisor_out   head magnitude, 0 when empty
//   Divisor_sign  head sign, 0 when empty
//   Divisor_zero  head magnitude is zero (0 unless DIVISOR_ZERO_FLAG_EN)
//   count         occupancy 0..DEPTH
module divisor_queue #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     Reset,
  input  logic                     W_ctrl,
  input  logic                     Signed_mode,
  input  logic [WIDTH-1:0]         Divisor_in,
  input  logic                     Clear,
  input  logic                     Pop,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         Divisor_out,
  output logic                     Divisor_sign,
  output logic                     Divisor_zero,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  typedef struct packed {
    logic             sign;
    logic [WIDTH-1:0] mag;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count_q;
  entry_t          head_q;

  entry_t          push_entry;
  entry_t          head_next;
  logic            do_push;
  logic            do_pop;
  logic [CW-1:0]   count_next;
  logic [PW-1:0]   rd_next;

  // Status flags come straight off the count register, so they only move on edges or reset.
  assign in_ready     = (count_q != CNT_FULL);
  assign out_valid    = (count_q != '0);
  assign count        = count_q;
  assign Divisor_out  = head_q.mag;
  assign Divisor_sign = head_q.sign;

  // A pop at full frees a slot on the same edge, so the push may ride along.
  assign do_pop  = Pop & out_valid;
  assign do_push = W_ctrl & (in_ready | do_pop);

  // Two's-complement negation maps the most negative value onto itself, which read
  // as unsigned is exactly its magnitude.
  always_comb begin
    push_entry = '0;
    if (Signed_mode && Divisor_in[WIDTH-1]) begin
      push_entry.sign = 1'b1;
      push_entry.mag  = ~Divisor_in + WIDTH'(1);
    end else begin
      push_entry.sign = 1'b0;
      push_entry.mag  = Divisor_in;
    end
  end

  always_comb begin
    count_next = count_q;
    rd_next    = rd_ptr;
    head_next  = '0;
    if (do_pop) rd_next = rd_ptr + PTR_ONE;
    case ({do_push, do_pop})
      2'b10:   count_next = count_q + CNT_ONE;
      2'b01:   count_next = count_q - CNT_ONE;
      default: count_next = count_q;
    endcase
    // When nothing older survives this edge the new head is the word being pushed,
    // which is not in the array yet, so bypass it.
    if (count_next != '0) begin
      if ((count_q == '0) || (count_q == CNT_ONE && do_pop))
        head_next = push_entry;
      else
        head_next = mem[rd_next];
    end
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      head_q  <= '0;
    end else if (Clear) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      head_q  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      rd_ptr  <= rd_next;
      count_q <= count_next;
      head_q  <= head_next;
    end
  end

  // Array contents need no reset; only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (do_push && !Clear) mem[wr_ptr] <= push_entry;
  end

`ifdef DIVISOR_ZERO_FLAG_EN
  logic zero_q;

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset)
      zero_q <= 1'b0;
    else if (Clear)
      zero_q <= 1'b0;
    else
      zero_q <= (count_next != '0) && (head_next.mag == '0);
  end

  assign Divisor_zero = zero_q;
`else
  assign Divisor_zero = 1'b0;
`endif

endmodule
